// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 13-bit ROM/RAM bus.
// Grants fetch or data, decodes region, strobes memory for 1+WAIT cycles, acks once.
module mem_bus_arbiter #(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [12:0] i_addr,
  output logic [7:0]  i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [12:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic [7:0]  d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [12:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        rom_rd,
  output logic        ram_rd,
  output logic        ram_wr
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t          r_state;
  logic            r_last_d;
  logic            r_gnt_d;
  logic            r_we;
  logic            r_ram;
  logic [CW-1:0]   r_cnt;

  logic            w_pick_d;
  logic            w_sel_ram;
  logic            w_sel_we;
  logic [12:0]     w_sel_addr;

  // On a tie the requester not granted last wins
  assign w_pick_d   = d_req & (~i_req | ~r_last_d);
  assign w_sel_addr = w_pick_d ? d_addr : i_addr;
  assign w_sel_ram  = (w_sel_addr[12:11] == 2'b11);
  assign w_sel_we   = w_pick_d & d_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last_d  <= 1'b1;
      r_gnt_d   <= 1'b0;
      r_we      <= 1'b0;
      r_ram     <= 1'b0;
      r_cnt     <= '0;
      i_rdata   <= '0;
      i_ack     <= 1'b0;
      d_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rom_rd    <= 1'b0;
      ram_rd    <= 1'b0;
      ram_wr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req || d_req) begin
            r_gnt_d  <= w_pick_d;
            r_we     <= w_sel_we;
            r_ram    <= w_sel_ram;
            r_cnt    <= w_sel_ram ? CW'(RAM_WAIT) : CW'(ROM_WAIT);
            mem_addr <= w_sel_addr;
            if (w_pick_d) mem_wdata <= d_wdata;
            // A write into ROM raises no strobe at all
            rom_rd   <= ~w_sel_ram & ~w_sel_we;
            ram_rd   <= w_sel_ram & ~w_sel_we;
            ram_wr   <= w_sel_ram & w_sel_we;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            rom_rd <= 1'b0;
            ram_rd <= 1'b0;
            ram_wr <= 1'b0;
            if (r_gnt_d) begin
              d_ack <= 1'b1;
              d_err <= r_we & ~r_ram;
              if (!r_we) d_rdata <= mem_rdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= mem_rdata;
            end
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          i_ack    <= 1'b0;
          d_ack    <= 1'b0;
          d_err    <= 1'b0;
          r_last_d <= r_gnt_d;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequencer and arbiter for the shared 13-bit memory bus. Two requesters share the single ROM/RAM address/data path: the instruction-fetch unit (read-only) and the data-access unit (read/write). The block grants one requester at a time and decodes the target region: ROM at 0000H–17FFH, RAM at 1800H–1FFFH. It then drives the ROM/RAM strobes for a per-region access length and returns read data with a one-cycle acknowledge. It sits between the CPU state controller/datapath and the rom/ram instances, replacing direct address-decode strobing.

## Interface
- ROM_WAIT, 1, extra access cycles for ROM (0..3)
- RAM_WAIT, 0, extra access cycles for RAM (0..3)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, level, held until i_ack
- i_addr  in  13  fetch address, stable while i_req high
- i_rdata  out  8  fetch read data, valid with i_ack
- i_ack  out  1  fetch done, one-cycle pulse
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = write, 0 = read, stable while d_req high
- d_addr  in  13  data address
- d_wdata  in  8  write data
- d_rdata  out  8  data read data, valid with d_ack
- d_ack  out  1  data done, one-cycle pulse
- d_err  out  1  pulses with d_ack when a write targeted ROM
- mem_addr  out  13  address to rom/ram
- mem_wdata  out  8  write data to ram
- mem_rdata  in  8  read data from the selected memory (combinational, valid during strobe)
- rom_rd  out  1  ROM read strobe
- ram_rd  out  1  RAM read strobe
- ram_wr  out  1  RAM write strobe

## Operation
- Region decode: RAM when addr[12:11] == 2'b11, otherwise ROM. Decode is applied to the granted address only.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any request is pending, grant it, latch addr/we/wdata/region into mem_addr/mem_wdata/region reg, load wait counter with the region's WAIT, then go to ACCESS. With no request, stay in IDLE.
- Arbitration when both requests are pending: round-robin on the last grant. The requester not granted last wins. After reset, last grant = data, so fetch wins the first tie. A single pending request is always granted.
- ACCESS:
  - Strobe for the granted operation stays high for all cycles in the state: rom_rd for a ROM read, ram_rd for a RAM read, ram_wr for a RAM write. At most one strobe is high.
  - The counter decrements each cycle. On the cycle the count is 0, read data is captured from mem_rdata into the grantee's rdata register, then go to RESP.
- Write to ROM: no strobe is asserted. The access still takes the ACCESS cycles (1+ROM_WAIT), then d_err = 1 with d_ack.
- RESP: the grantee's ack is high for exactly one cycle, the last-grant register is updated, then go to IDLE.
- Strobes are low in IDLE and RESP.
- i_rdata/d_rdata hold their value until the next read completes for that requester.
- Requesters must deassert req in the cycle after ack. A req still high in IDLE is a new request.
- rst asserted at any time, including mid-ACCESS: state returns to IDLE immediately, the in-flight access is abandoned with no ack, and last grant is set to data.

## Timing
- Reset values: all strobes, i_ack, d_ack, d_err = 0; mem_addr = 0; mem_wdata = 0; i_rdata = d_rdata = 0; state IDLE.
- A request sampled high in IDLE at edge t gives:
  - strobes high from t through t+WAIT (1+WAIT cycles)
  - ack high in the cycle after edge t+1+WAIT
- Request-to-ack latency is 2+WAIT cycles: RAM default 2, ROM default 3.
- Throughput: one access per 3+WAIT cycles, counting the IDLE cycle.
- mem_addr/mem_wdata are registered and stable for the whole ACCESS phase. They hold their value after the access.
- A request arriving during ACCESS/RESP waits. It is considered at the next IDLE.

## Test plan
- Reset, then d_req read at 1805H, mem_rdata=3CH → ram_rd high 1 cycle with mem_addr=1805H, d_ack 2 cycles after the request, d_rdata=3CH, d_err=0.
- i_req at 0010H, ROM_WAIT=1, mem_rdata=A7H → rom_rd high 2 cycles, i_ack 3 cycles after the request, i_rdata=A7H.
- d_req write 5AH to 1FFFH → ram_wr high 1 cycle with mem_wdata=5AH; then d_req write to 17FFH → no strobe, d_ack with d_err=1.
- i_req and d_req asserted together right after reset, both held → fetch served first, then data; repeated ties alternate fetch/data.
- Address boundaries: 17FFH selects ROM (rom_rd), 1800H selects RAM (ram_rd), 0000H selects ROM.
- Assert rst in the first ACCESS cycle of a ROM read → strobes drop immediately, no i_ack; state is IDLE after rst is released; the next tie grants fetch.
